scratchpad_controller: RTL
==========================

# scratchpad_controller

Parametrised single-port scratchpad memory controller. It replaces the fixed 8-bit, 4-entry controller with configurable data width and depth, and adds:
- a valid/ready request handshake with a registered response;
- an auto-incrementing address pointer;
- a multi-cycle atomic swap;
- a sequential whole-memory clear.

It sits between the instruction decoder and the on-chip RAM array, which it contains.

## Interface
- DATA_WIDTH, default 8: width of every stored word and of req_data/rsp_data.
- ADDR_BITS, default 4: address width; DEPTH = 2**ADDR_BITS words.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  reset, synchronous, active-low; clock clock.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_op  in  3  000 NOP, 001 LOAD, 010 STORE, 011 SWAP, 100 SETPTR, 101 CLEAR; 110/111 are treated as NOP.
- req_use_ptr  in  1  1 = address comes from ptr (LOAD/STORE/SWAP only); 0 = address comes from req_addr.
- req_addr  in  ADDR_BITS  explicit address; also the SETPTR value.
- req_data  in  DATA_WIDTH  write data for STORE/SWAP.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_WIDTH  response data; holds its last value between pulses.
- ptr  out  ADDR_BITS  current pointer value.
- busy  out  1  equals ~req_ready.

## Operation
- A request is accepted on a rising edge where req_valid && req_ready. Inputs are sampled only at acceptance.
- Responses have no backpressure; the consumer must take rsp_data whenever rsp_valid is high.
- FSM states: IDLE, RMW, CLR. req_ready = (state == IDLE).
- IDLE accept:
  - LOAD: reads mem[a]; rsp_data <= mem[a]; rsp_valid pulses.
  - STORE: mem[a] <= req_data; no response.
  - SWAP: latches mem[a] and a; goes to RMW.
  - SETPTR: ptr <= req_addr; no response.
  - CLEAR: clr_cnt <= 0; goes to CLR.
  - NOP, 110, 111: no effect, no response.
- Address a = req_use_ptr ? ptr : req_addr.
- Pointer post-increment: when LOAD, STORE or SWAP is accepted with req_use_ptr = 1, ptr <= ptr + 1 mod DEPTH at the accept edge. ptr = DEPTH-1 wraps to 0.
- RMW: on the next edge, mem[a] <= latched req_data; rsp_data <= latched old value; rsp_valid pulses; return to IDLE.
- CLR: on each edge, mem[clr_cnt] <= 0 and clr_cnt increments. On the edge that writes address DEPTH-1: rsp_data <= 0, rsp_valid pulses, return to IDLE.
- Memory contents are not affected by reset. Contents before the first write or CLEAR are undefined.
- Read-after-write: a LOAD accepted on the edge immediately after a STORE to the same address returns the stored value.
- Reset (reset == 0 at an edge): state <= IDLE, ptr <= 0, rsp_valid <= 0, rsp_data <= 0, clr_cnt <= 0.
  - Reset during RMW abandons the write; the location keeps its old value.
  - Reset during CLR leaves the locations already cleared at 0 and the rest unchanged.
  - Reset has priority over every request.

## Timing
- Reset values: req_ready 1, busy 0, rsp_valid 0, rsp_data 0, ptr 0.
- LOAD accepted at edge N: rsp_valid is high for the cycle after edge N; rsp_data is valid from edge N. Back-to-back LOADs sustain one per cycle.
- STORE accepted at edge N: memory is updated at edge N. Throughput is one per cycle.
- SWAP accepted at edge N:
  - req_ready is low for the cycle after edge N.
  - The write and rsp_valid take effect at edge N+1.
  - The next request can be accepted at edge N+2.
- CLEAR accepted at edge N:
  - Address k is written at edge N+1+k.
  - rsp_valid is high after edge N+DEPTH.
  - req_ready returns high after edge N+DEPTH.
  - Total busy time is DEPTH cycles.
- ptr updates at the accept edge. A request in the following cycle that uses the pointer sees the incremented value.

## Test plan
- Reset check: hold reset low for 2 cycles, then release. Required: ptr=0, rsp_valid=0, rsp_data=0, req_ready=1.
- Store/load, DATA_WIDTH=8, ADDR_BITS=4:
  - STORE 0xA5→addr 3, then LOAD addr 3 on the next cycle. Required: rsp_valid one cycle later with rsp_data=0xA5.
  - STORE 0x3C→addr 15, then LOAD addr 15. Required: rsp_data=0x3C.
- Pointer: SETPTR 14, then STORE 0x11 and 0x22 and 0x33 with use_ptr. Required: writes land at 14, 15, 0; ptr ends at 1. Then LOAD addr 0 returns 0x33.
- SWAP: mem[5]=0x42, SWAP addr 5 data 0x99. Required:
  - req_ready low for 1 cycle;
  - rsp_data=0x42;
  - a subsequent LOAD addr 5 returns 0x99;
  - a SWAP held valid back-to-back is accepted only every 2nd cycle.
- CLEAR: fill all 16 words with 0xFF, then CLEAR. Required:
  - busy for exactly 16 cycles;
  - rsp_valid with rsp_data=0 at the end;
  - all LOADs return 0.
- Reset mid-CLEAR: assert reset after 5 clear cycles. Required: addresses 0..4 read 0, addresses 5..15 read 0xFF, ptr=0, req_ready=1.

Source files
------------

// File: rtl/scratchpad_controller_if.sv
// scratchpad_controller_if
//   Request/response bundle between the instruction decoder (master) and the
//   scratchpad controller (slave).
//   req_valid/req_ready  : request handshake, accepted when both are high
//   req_op               : 000 NOP, 001 LOAD, 010 STORE, 011 SWAP, 100 SETPTR, 101 CLEAR
//   req_use_ptr          : take the address from ptr instead of req_addr
//   req_addr, req_data   : explicit address / SETPTR value, and write data
//   rsp_valid, rsp_data  : one-cycle response pulse and held response data
//   ptr, busy            : current pointer value, and ~req_ready
interface scratchpad_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic                  req_use_ptr;
  logic [ADDR_BITS-1:0]  req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_BITS-1:0]  ptr;
  logic                  busy;

  modport master (
    output req_valid, req_op, req_use_ptr, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data, ptr, busy
  );

  modport slave (
    input  req_valid, req_op, req_use_ptr, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data, ptr, busy
  );
endinterface

// File: rtl/scratchpad_controller.sv
// scratchpad_controller
//   Single-port scratchpad RAM with a request/response front end, an
//   auto-incrementing address pointer, a two-cycle atomic swap and a
//   sequential whole-memory clear.
//   clock : rising-edge clock for all state
//   reset : synchronous, active-low
//   bus   : scratchpad_controller_if slave side (request, response, ptr, busy)
module scratchpad_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 4
) (
  input logic                    clock,
  input logic                    reset,
  scratchpad_controller_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_STORE  = 3'b010;
  localparam logic [2:0] OP_SWAP   = 3'b011;
  localparam logic [2:0] OP_SETPTR = 3'b100;
  localparam logic [2:0] OP_CLEAR  = 3'b101;

  typedef enum logic [1:0] {IDLE, RMW, CLR} state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0]  ptr_q;
  logic [ADDR_BITS-1:0]  clr_cnt;
  logic [ADDR_BITS-1:0]  swap_addr;
  logic [DATA_WIDTH-1:0] swap_old;
  logic [DATA_WIDTH-1:0] swap_data;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic                  ready;
  logic                  accept;
  logic                  ptr_op;
  logic [ADDR_BITS-1:0]  req_a;

  logic                  mem_we;
  logic [ADDR_BITS-1:0]  mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign ready  = (state == IDLE);
  assign accept = bus.req_valid && ready;
  assign req_a  = bus.req_use_ptr ? ptr_q : bus.req_addr;
  // Only memory-accessing ops advance the pointer.
  assign ptr_op = bus.req_use_ptr &&
                  ((bus.req_op == OP_LOAD) || (bus.req_op == OP_STORE) ||
                   (bus.req_op == OP_SWAP));

  assign bus.req_ready = ready;
  assign bus.busy      = ~ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.ptr       = ptr_q;

  // Next-state logic and the single RAM write port: STORE writes at accept,
  // SWAP writes one edge later from its latched copy, CLR sweeps zeros.
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_waddr  = req_a;
    mem_wdata  = bus.req_data;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.req_op)
            OP_STORE: mem_we = 1'b1;
            OP_SWAP:  state_next = RMW;
            OP_CLEAR: state_next = CLR;
            default:  ;
          endcase
        end
      end
      RMW: begin
        mem_we     = 1'b1;
        mem_waddr  = swap_addr;
        mem_wdata  = swap_data;
        state_next = IDLE;
      end
      CLR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
        if (clr_cnt == LAST_ADDR) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM array has no reset; a reset edge suppresses any in-flight write so an
  // interrupted SWAP or CLEAR leaves untouched locations as they were.
  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // SWAP operands are captured at accept and consumed in RMW.
  always_ff @(posedge clock) begin
    if (accept && (bus.req_op == OP_SWAP)) begin
      swap_addr <= req_a;
      swap_old  <= mem[req_a];
      swap_data <= bus.req_data;
    end
  end

  // Control state, pointer, clear counter and the response register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      ptr_q       <= '0;
      clr_cnt     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state       <= state_next;
      rsp_valid_q <= 1'b0;
      if (accept) begin
        case (bus.req_op)
          OP_LOAD: begin
            rsp_data_q  <= mem[req_a];
            rsp_valid_q <= 1'b1;
          end
          OP_SETPTR: ptr_q   <= bus.req_addr;
          OP_CLEAR:  clr_cnt <= '0;
          default:   ;
        endcase
        if (ptr_op) begin
          ptr_q <= ptr_q + 1'b1;
        end
      end
      if (state == RMW) begin
        rsp_data_q  <= swap_old;
        rsp_valid_q <= 1'b1;
      end
      if (state == CLR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          rsp_data_q  <= '0;
          rsp_valid_q <= 1'b1;
        end
      end
    end
  end
endmodule
